// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake and line-side status bundle for uart_tx_cfg.
// The slave modport belongs to the transmitter, and the master modport belongs to the host or bench.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          tx_start;
  logic [DATA_BITS-1:0]          tx_data;
  logic                          tx_ready;
  logic                          tx_serial;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;

  modport master (
    output tx_start, tx_data,
    input  tx_ready, tx_serial, tx_busy, fifo_count, overflow
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_ready, tx_serial, tx_busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a small FIFO; a push reaches the line one cycle after the FIFO write.
// tx_ready drops while the FIFO is full; pushes attempted then are dropped and latch overflow.
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_cfg_if.slave bus
);
  localparam int DIVISOR = CLK_FREQ / BAUD_RATE;
  localparam int CW      = $clog2(DIVISOR);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int NW      = AW + 1;
  localparam int BW      = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_serial_q, tx_serial_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 ready, push, pop, tick, fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  assign ready         = (count_q != NW'(FIFO_DEPTH));
  assign push          = bus.tx_start && ready;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign tick          = (state_q != S_IDLE) && (baud_cnt_q == CW'(DIVISOR - 1));

  // Next-state and datapath; the head is loaded and its parity precomputed at pop time.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          state_d = S_START;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 1);
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (fifo_nonempty) begin
              pop     = 1'b1;
              state_d = S_START;
              shift_d = head;
              par_d   = (^head) ^ (PARITY == 1);
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the state being entered so it changes on the same edge.
  always_comb begin
    tx_serial_d = 1'b1;
    case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = shift_d[0];
      S_PARITY: tx_serial_d = par_d;
      default:  tx_serial_d = 1'b1;
    endcase
  end

  always_comb begin
    baud_cnt_d = (state_q == S_IDLE || tick) ? '0 : baud_cnt_q + 1'b1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (bus.tx_start & ~ready);
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_serial_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tx_serial_q <= tx_serial_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  assign bus.tx_ready   = ready;
  assign bus.tx_serial  = tx_serial_q;
  assign bus.tx_busy    = (state_q != S_IDLE) || fifo_nonempty;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three instances (8N1, 7E2, 8O1) at DIVISOR=10, checked against a bit-list line model.
module tb_uart_tx_cfg;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_cfg_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_b ();
  uart_tx_cfg_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst_a), .bus(if_a.slave));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst_b), .bus(if_b.slave));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .rst(rst_c), .bus(if_c.slave));

  logic [2:0] ser, busy, rdy, ovf;
  logic [2:0] cnt [3];
  assign ser  = {if_c.tx_serial, if_b.tx_serial, if_a.tx_serial};
  assign busy = {if_c.tx_busy, if_b.tx_busy, if_a.tx_busy};
  assign rdy  = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
  assign ovf  = {if_c.overflow, if_b.overflow, if_a.overflow};
  assign cnt[0] = if_a.fifo_count;
  assign cnt[1] = if_b.fifo_count;
  assign cnt[2] = if_c.fifo_count;

  int cfg_db  [3] = '{8, 7, 8};
  int cfg_par [3] = '{0, 2, 1};
  int cfg_st  [3] = '{1, 2, 1};

  int   errors = 0;
  int   checks = 0;
  int   idle_viol = 0;
  bit   mon_en = 1'b0;
  logic exp_bits [$];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 3; u++)
        if (busy[u] === 1'b0 && ser[u] === 1'b0) idle_viol++;
    end
  end

  // Expected line levels, one entry per bit-time, straight from the frame format.
  function automatic void add_frame(input int u, input logic [8:0] d);
    logic p;
    p = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[u]; i++) begin
      exp_bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (cfg_par[u] == 1) exp_bits.push_back(~p);
    else if (cfg_par[u] == 2) exp_bits.push_back(p);
    for (int i = 0; i < cfg_st[u]; i++) exp_bits.push_back(1'b1);
  endfunction

  task automatic drive(input int u, input logic s, input logic [8:0] d);
    case (u)
      0: begin if_a.tx_start = s; if_a.tx_data = d[7:0]; end
      1: begin if_b.tx_start = s; if_b.tx_data = d[6:0]; end
      default: begin if_c.tx_start = s; if_c.tx_data = d[7:0]; end
    endcase
  endtask

  task automatic push1(input int u, input logic [8:0] d);
    drive(u, 1'b1, d);
    @(negedge clk);
    drive(u, 1'b0, d);
  endtask

  // Waits for a start bit, then compares every cycle against exp_bits; expects idle right after.
  task automatic watch_stream(input int u, input string nm);
    int   n, waited, bad_line, bad_busy, first_bad;
    logic got_first, want_first;
    n = exp_bits.size() * DIV;
    waited = 0; bad_line = 0; bad_busy = 0; first_bad = -1;
    got_first = 1'b0; want_first = 1'b0;
    while (ser[u] !== 1'b0 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (ser[u] !== 1'b0) begin
      errors++;
      $display("FAIL %s start: line=%b after %0d cycles, want start bit 0", nm, ser[u], waited);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (ser[u] !== exp_bits[i / DIV]) begin
        if (first_bad < 0) begin
          first_bad = i; got_first = ser[u]; want_first = exp_bits[i / DIV];
        end
        bad_line++;
      end
      if (busy[u] !== 1'b1) bad_busy++;
    end
    checks++;
    if (bad_line != 0) begin
      errors++;
      $display("FAIL %s line: %0d wrong cycles, first at cycle %0d got %b want %b",
               nm, bad_line, first_bad, got_first, want_first);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy_during: low for %0d of %0d cycles, want 0", nm, bad_busy, n);
    end
    @(negedge clk);
    checks++;
    if ({ser[u], busy[u]} !== 2'b10) begin
      errors++;
      $display("FAIL %s end_idle: serial,busy=%b%b want 10 at cycle %0d", nm, ser[u], busy[u], n);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int u = 0; u < 3; u++) drive(u, 1'b0, 9'd0);
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if ({ser[u], busy[u], rdy[u], cnt[u], ovf[u]} !== 7'b1010000) begin
        errors++;
        $display("FAIL reset_state u%0d: ser=%b busy=%b rdy=%b cnt=%0d ovf=%b want 1 0 1 0 0",
                 u, ser[u], busy[u], rdy[u], cnt[u], ovf[u]);
      end
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_frame_8n1();
    logic [8:0] v;
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 9'h0A5 : 9'($urandom_range(0, 255));
      exp_bits.delete();
      add_frame(0, v);
      push1(0, v);
      checks++;
      if ({cnt[0], ser[0], busy[0]} !== 5'b00111) begin
        errors++;
        $display("FAIL latency_8n1: cnt=%0d ser=%b busy=%b want cnt=1 ser=1 busy=1",
                 cnt[0], ser[0], busy[0]);
      end
      watch_stream(0, "frame_8n1");
    end
  endtask

  task automatic test_parity_even_7e2();
    logic [8:0] v;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? 9'h031 : 9'($urandom_range(0, 127));
      exp_bits.delete();
      add_frame(1, v);
      push1(1, v);
      watch_stream(1, "frame_7e2");
    end
  endtask

  task automatic test_parity_odd();
    logic [8:0] v;
    v = 9'($urandom_range(0, 255));
    exp_bits.delete();
    add_frame(2, 9'h000);
    add_frame(2, 9'h001);
    add_frame(2, v);
    fork
      begin
        drive(2, 1'b1, 9'h000); @(negedge clk);
        drive(2, 1'b1, 9'h001); @(negedge clk);
        drive(2, 1'b1, v);      @(negedge clk);
        drive(2, 1'b0, 9'h000);
      end
      watch_stream(2, "frame_8o1");
    join
  endtask

  task automatic test_fifo_burst();
    logic [8:0] v [6];
    int exp_cnt [5] = '{1, 1, 2, 3, 4};
    for (int k = 0; k < 6; k++) v[k] = 9'($urandom_range(0, 255));
    exp_bits.delete();
    for (int k = 0; k < 5; k++) add_frame(0, v[k]);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          drive(0, 1'b1, v[k]);
          @(negedge clk);
          if (k < 5) begin
            checks++;
            if (cnt[0] !== 3'(exp_cnt[k])) begin
              errors++;
              $display("FAIL burst_count push%0d: cnt=%0d want %0d", k, cnt[0], exp_cnt[k]);
            end
          end
          if (k == 4) begin
            checks++;
            if ({rdy[0], ovf[0]} !== 2'b00) begin
              errors++;
              $display("FAIL burst_full: ready=%b overflow=%b want 0 0", rdy[0], ovf[0]);
            end
          end
        end
        drive(0, 1'b0, 9'd0);
        checks++;
        if (ovf[0] !== 1'b1) begin
          errors++;
          $display("FAIL burst_overflow: overflow=%b want 1", ovf[0]);
        end
      end
      watch_stream(0, "burst_b2b");
    join
  endtask

  task automatic test_push_during_data();
    logic [8:0] v0, v1;
    v0 = 9'($urandom_range(0, 255));
    v1 = 9'($urandom_range(0, 255));
    exp_bits.delete();
    add_frame(0, v0);
    add_frame(0, v1);
    fork
      begin
        push1(0, v0);
        repeat (35) @(negedge clk);
        drive(0, 1'b1, v1);
        @(negedge clk);
        drive(0, 1'b0, ~v1);
        checks++;
        if (cnt[0] !== 3'd1) begin
          errors++;
          $display("FAIL mid_data_queue: cnt=%0d want 1", cnt[0]);
        end
      end
      watch_stream(0, "push_during_data");
    join
  endtask

  task automatic test_reset_mid_frame();
    int waited, lows;
    waited = 0; lows = 0;
    drive(0, 1'b1, 9'($urandom_range(0, 255))); @(negedge clk);
    drive(0, 1'b1, 9'($urandom_range(0, 255))); @(negedge clk);
    drive(0, 1'b0, 9'd0);
    while (ser[0] !== 1'b0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (ser[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_start: line=%b want start bit 0", ser[0]);
    end
    repeat (45) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    checks++;
    if ({ser[0], busy[0], cnt[0], ovf[0], rdy[0]} !== 7'b1000001) begin
      errors++;
      $display("FAIL rst_mid_state: ser=%b busy=%b cnt=%0d ovf=%b rdy=%b want 1 0 0 0 1",
               ser[0], busy[0], cnt[0], ovf[0], rdy[0]);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ser[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL rst_no_residual: %0d non-idle cycles after reset, want 0", lows);
    end
  endtask

  task automatic test_idle_line();
    checks++;
    if (idle_viol != 0) begin
      errors++;
      $display("FAIL idle_line_low: %0d idle cycles with line low, want 0", idle_viol);
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity_even_7e2();
    test_parity_odd();
    test_fifo_burst();
    test_push_during_data();
    test_reset_mid_frame();
    test_idle_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
